systolic_mac_pe: RTL and testbench
==================================

Name: systolic_mac_pe

Overview:
- Parametrised next-generation processing element for the systolic matrix-multiply array.
- Takes one row/column operand pair per cycle, forwards both to its right/down neighbours with one-cycle latency, and multiplies them in a MUL_LAT-stage pipelined multiplier. The multiply accepts a new pair every cycle.
- Accumulates products into an ACC_W accumulator, with per-dot-product clear/last framing, signed/unsigned mode, optional saturation and a sticky overflow flag.

Parameters:
- DATA_W, 16, operand width of row_in/col_in.
- ACC_W, 40, accumulator and result width; must be >= 2*DATA_W.
- MUL_LAT, 2, multiplier pipeline register stages (>=1), product register included.
- SAT, 0, 1 = clamp accumulator on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid this cycle
- row_in  in  DATA_W  row operand
- col_in  in  DATA_W  column operand
- acc_clr  in  1  with in_valid: first term of a new dot product
- acc_last  in  1  with in_valid: final term; publish result
- is_signed  in  1  with in_valid: 1 = signed operands and accumulation
- row_out  out  DATA_W  forwarded row operand
- col_out  out  DATA_W  forwarded column operand
- fwd_valid  out  1  forwarded operands valid
- acc_out  out  ACC_W  published dot-product result
- acc_valid  out  1  one-cycle pulse: acc_out updated
- ovf  out  1  overflow occurred in the dot product most recently published

Behaviour:
- Reset: all outputs 0; accumulator 0; all pipeline valid tags 0; internal sticky overflow 0.
- Reset mid-operation flushes all in-flight terms. No acc_valid is produced for them.
- Forwarding:
  - When in_valid=1, row_out/col_out <= row_in/col_in on the next edge, and fwd_valid <= 1.
  - When in_valid=0, fwd_valid <= 0 and row_out/col_out hold their values.
- Multiply pipeline:
  - Operands are sign-extended (is_signed=1) or zero-extended (is_signed=0) to 2*DATA_W before multiplying.
  - The product is sign/zero-extended to ACC_W.
  - in_valid, acc_clr, acc_last and is_signed travel with the data as tags through all MUL_LAT stages.
  - Throughput is one term per cycle, with no stalls.
- Accumulate stage (one edge after the product stage):
  - Tag valid and clr=1: acc <= product; internal ovf <= 0.
  - Tag valid and clr=0: acc <= acc + product, evaluated in the tag's signed/unsigned sense.
  - Overflow check: signed uses operand-sign vs sum-sign; unsigned uses carry out of bit ACC_W-1.
  - On overflow, internal ovf is set and stays set until the next clr term. With SAT=1, acc clamps to the maximum/minimum representable value (unsigned maximum is all-ones). With SAT=0, acc wraps.
- Publish:
  - On the same edge as the accumulate, if the tag has last=1: acc_out <= new acc value, ovf <= new internal ovf, acc_valid <= 1. Otherwise acc_valid <= 0.
  - acc_out and ovf hold their values between publishes.
- Latency: a term with in_valid in cycle 0 yields acc_valid high in cycle MUL_LAT+1.
- clr and last set together: single-term dot product, acc_out = product.
- A clr term may directly follow a last term in the next cycle. Back-to-back dot products run with no bubble.
- A terms with clr=0 arriving after a last term continues accumulating from the published value.
- Terms with in_valid=0: no accumulator change; all tags are ignored.
- Mixing is_signed values within one dot product: the result is undefined, and the bench does not check it.

Test Plan:
- Config: DATA_W=8, ACC_W=24, MUL_LAT=2, SAT=0. Stimulus: cycle 0, row=0xFD (-3), col=0x05, clr=last=1, is_signed=1 -> acc_valid in cycle 3 only; acc_out=0xFFFFF1 (-15); ovf=0.
- Same config. Stimulus: cycles 0-3, 0xFF*0xFF unsigned; clr in cycle 0, last in cycle 3 -> acc_out=0x03F804 (260100) in cycle 6; ovf=0; acc_valid low in cycles 3-5.
- Config: ACC_W=16, signed. Stimulus: 127*127 three times (clr first, last third) -> SAT=0: acc_out=0xBD03, ovf=1. SAT=1: acc_out=0x7FFF, ovf=1. A following single-term 2*3 with clr+last -> acc_out=6, ovf=0.
- Forwarding: in_valid with row=0x12, col=0x34 in cycle 0, idle in cycle 1 -> cycle 1: row_out=0x12, col_out=0x34, fwd_valid=1; cycle 2: fwd_valid=0, values held.
- Reset mid-operation: last term issued in cycle 0, rst=1 in cycle 1 -> acc_valid never asserts; all outputs 0 from cycle 2.
- Back-to-back: cycles 0-1 are dot product A (1*2, 3*4), cycles 2-3 are dot product B (5*6, 7*8), contiguous -> acc_valid pulses in cycle 4 (acc_out=14) and cycle 6 (acc_out=86).

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Systolic-array processing element: forwards row/column operands to its
// neighbours and accumulates their products into framed dot products.
// Products run through a MUL_LAT-deep pipeline with their framing tags,
// then one accumulate/publish stage follows.
module systolic_mac_pe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned MUL_LAT = 2,
    parameter bit          SAT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] row_in,
    input  logic [DATA_W-1:0] col_in,
    input  logic              acc_clr,
    input  logic              acc_last,
    input  logic              is_signed,
    output logic [DATA_W-1:0] row_out,
    output logic [DATA_W-1:0] col_out,
    output logic              fwd_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    // One multiplier pipeline stage: product plus the tags that travel with it.
    typedef struct packed {
        logic             valid;
        logic             clr;
        logic             last;
        logic             sgn;
        logic [ACC_W-1:0] prod;
    } stage_t;

    logic [PROD_W-1:0] row_ext;
    logic [PROD_W-1:0] col_ext;
    logic [PROD_W-1:0] prod_full;
    logic [ACC_W-1:0]  prod_ext;

    stage_t pipe_q [MUL_LAT];
    stage_t tail;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_sticky_q;
    logic             ovf_sticky_d;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_w;
    logic             ovf_signed;
    logic             ovf_unsigned;
    logic             add_ovf;
    logic [ACC_W-1:0] sat_val;

    // Operand extension and full-width product; the low PROD_W bits are exact
    // in both signed and unsigned sense, so one unsigned multiplier serves both.
    always_comb begin
        row_ext   = is_signed ? {{DATA_W{row_in[DATA_W-1]}}, row_in}
                              : {{DATA_W{1'b0}}, row_in};
        col_ext   = is_signed ? {{DATA_W{col_in[DATA_W-1]}}, col_in}
                              : {{DATA_W{1'b0}}, col_in};
        prod_full = row_ext * col_ext;
        prod_ext  = is_signed ? ACC_W'($signed(prod_full)) : ACC_W'(prod_full);
    end

    // Multiplier pipeline; only the valid tags need reset, data just shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
        end else begin
            pipe_q[0].valid <= in_valid;
            pipe_q[0].clr   <= acc_clr;
            pipe_q[0].last  <= acc_last;
            pipe_q[0].sgn   <= is_signed;
            pipe_q[0].prod  <= prod_ext;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail = pipe_q[MUL_LAT-1];

    // Adder with signed (operand vs sum sign) and unsigned (carry) overflow,
    // plus the clamp value for saturating builds.
    always_comb begin
        sum          = {1'b0, acc_q} + {1'b0, tail.prod};
        sum_w        = sum[ACC_W-1:0];
        ovf_signed   = (acc_q[ACC_W-1] == tail.prod[ACC_W-1]) &&
                       (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
        ovf_unsigned = sum[ACC_W];
        add_ovf      = tail.sgn ? ovf_signed : ovf_unsigned;
        if (!tail.sgn) begin
            sat_val = '1;
        end else if (acc_q[ACC_W-1]) begin
            sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Next accumulator and sticky overflow for the term leaving the pipeline.
    always_comb begin
        acc_d        = acc_q;
        ovf_sticky_d = ovf_sticky_q;
        if (tail.valid) begin
            if (tail.clr) begin
                acc_d        = tail.prod;
                ovf_sticky_d = 1'b0;
            end else begin
                ovf_sticky_d = ovf_sticky_q | add_ovf;
                acc_d        = (SAT && add_ovf) ? sat_val : sum_w;
            end
        end
    end

    // Accumulator state and result publication on the last term.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            acc_out      <= '0;
            ovf          <= 1'b0;
            acc_valid    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
            acc_valid    <= tail.valid & tail.last;
            if (tail.valid && tail.last) begin
                acc_out <= acc_d;
                ovf     <= ovf_sticky_d;
            end
        end
    end

    // Neighbour forwarding: operands hold when no new pair arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_out   <= '0;
            col_out   <= '0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= in_valid;
            if (in_valid) begin
                row_out <= row_in;
                col_out <= col_in;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: four configurations share one stimulus stream
// and are checked each cycle against an arithmetic dot-product model.
module tb_systolic_mac_pe;

    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       acc_clr;
    logic       acc_last;
    logic       is_signed;
    logic [7:0] row_in;
    logic [7:0] col_in;

    logic [7:0]  ro [NC];
    logic [7:0]  co [NC];
    logic        fv [NC];
    logic        av [NC];
    logic        ov [NC];
    logic [23:0] ao_a;
    logic [15:0] ao_b;
    logic [15:0] ao_c;
    logic [23:0] ao_d;
    logic [63:0] ao [NC];

    assign ao[0] = 64'(ao_a);
    assign ao[1] = 64'(ao_b);
    assign ao[2] = 64'(ao_c);
    assign ao[3] = 64'(ao_d);

    // Per-configuration accumulator width, saturation and multiplier latency.
    int cw  [NC] = '{24, 16, 16, 24};
    bit cst [NC] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int cml [NC] = '{2, 2, 2, 3};

    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .MUL_LAT(2), .SAT(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row_in(row_in), .col_in(col_in),
        .acc_clr(acc_clr), .acc_last(acc_last), .is_signed(is_signed),
        .row_out(ro[0]), .col_out(co[0]), .fwd_valid(fv[0]),
        .acc_out(ao_a), .acc_valid(av[0]), .ovf(ov[0]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_LAT(2), .SAT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row_in(row_in), .col_in(col_in),
        .acc_clr(acc_clr), .acc_last(acc_last), .is_signed(is_signed),
        .row_out(ro[1]), .col_out(co[1]), .fwd_valid(fv[1]),
        .acc_out(ao_b), .acc_valid(av[1]), .ovf(ov[1]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_LAT(2), .SAT(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row_in(row_in), .col_in(col_in),
        .acc_clr(acc_clr), .acc_last(acc_last), .is_signed(is_signed),
        .row_out(ro[2]), .col_out(co[2]), .fwd_valid(fv[2]),
        .acc_out(ao_c), .acc_valid(av[2]), .ovf(ov[2]));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .MUL_LAT(3), .SAT(1'b1)) u_dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row_in(row_in), .col_in(col_in),
        .acc_clr(acc_clr), .acc_last(acc_last), .is_signed(is_signed),
        .row_out(ro[3]), .col_out(co[3]), .fwd_valid(fv[3]),
        .acc_out(ao_d), .acc_valid(av[3]), .ovf(ov[3]));

    typedef struct {
        int         issue;
        bit         clr;
        bit         last;
        bit         sgn;
        logic [7:0] r;
        logic [7:0] c;
    } term_t;

    term_t       hist [$];
    logic [63:0] m_acc [NC];
    bit          m_ovf [NC];
    logic [63:0] e_out [NC];
    bit          e_ovf [NC];
    bit          e_v   [NC];
    logic [7:0]  e_row;
    logic [7:0]  e_col;
    bit          e_fv;
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One term folded into a w-bit dot product using plain integer arithmetic.
    function automatic void mac(input int w, input bit sat, input term_t t,
                                inout logic [63:0] acc, inout bit ovfi);
        longint rv, cv, p, a, s, maxv, minv;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        rv   = longint'(t.r);
        cv   = longint'(t.c);
        a    = longint'(acc);
        if (t.sgn) begin
            if (t.r[7]) rv -= 256;
            if (t.c[7]) cv -= 256;
            if (acc[w-1]) a -= longint'(1) << w;
            maxv = (longint'(1) << (w - 1)) - 1;
            minv = -(longint'(1) << (w - 1));
        end else begin
            maxv = (longint'(1) << w) - 1;
            minv = 0;
        end
        p = rv * cv;
        if (t.clr) begin
            s    = p;
            ovfi = 1'b0;
        end else begin
            s = a + p;
        end
        if (s > maxv || s < minv) begin
            ovfi = 1'b1;
            if (sat) s = (s > maxv) ? maxv : minv;
        end
        acc = 64'(s) & mask;
    endfunction

    // Drive one cycle, advance the model across its edge, then compare.
    task automatic step(input bit r, input bit v, input bit cl, input bit la, input bit sg,
                        input logic [7:0] a, input logic [7:0] b);
        term_t       t;
        logic [63:0] tacc;
        bit          tovf;
        rst = r; in_valid = v; acc_clr = cl; acc_last = la; is_signed = sg;
        row_in = a; col_in = b;
        if (r) begin
            hist.delete();
            for (int k = 0; k < NC; k++) begin
                m_acc[k] = '0; m_ovf[k] = 0; e_out[k] = '0; e_ovf[k] = 0; e_v[k] = 0;
            end
            e_row = '0; e_col = '0; e_fv = 0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                e_v[k] = 0;
                foreach (hist[i]) begin
                    if (hist[i].issue + cml[k] == cyc) begin
                        tacc = m_acc[k];
                        tovf = m_ovf[k];
                        mac(cw[k], cst[k], hist[i], tacc, tovf);
                        m_acc[k] = tacc;
                        m_ovf[k] = tovf;
                        if (hist[i].last) begin
                            e_out[k] = tacc; e_ovf[k] = tovf; e_v[k] = 1;
                        end
                    end
                end
            end
            while (hist.size() > 0 && hist[0].issue < cyc - 4) void'(hist.pop_front());
            if (v) begin
                t.issue = cyc; t.clr = cl; t.last = la; t.sgn = sg; t.r = a; t.c = b;
                hist.push_back(t);
                e_row = a; e_col = b; e_fv = 1;
            end else begin
                e_fv = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NC; k++) begin
            check_eq($sformatf("cfg%0d acc_out @%0d", k, cyc), ao[k], e_out[k]);
            check_eq($sformatf("cfg%0d acc_valid @%0d", k, cyc), 64'(av[k]), 64'(e_v[k]));
            check_eq($sformatf("cfg%0d ovf @%0d", k, cyc), 64'(ov[k]), 64'(e_ovf[k]));
            check_eq($sformatf("cfg%0d fwd_valid @%0d", k, cyc), 64'(fv[k]), 64'(e_fv));
            check_eq($sformatf("cfg%0d row_out @%0d", k, cyc), 64'(ro[k]), 64'(e_row));
            check_eq($sformatf("cfg%0d col_out @%0d", k, cyc), 64'(co[k]), 64'(e_col));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bit r, v, cl, la, cur_sgn;
        n_tests = 0; n_fail = 0; cyc = 0; cur_sgn = 0;
        rst = 1; in_valid = 0; acc_clr = 0; acc_last = 0; is_signed = 0;
        row_in = '0; col_in = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check_eq("reset acc_out", ao[0], 64'h0);

        // Single signed term -3*5, result visible three cycles later only.
        step(0, 1, 1, 1, 1, 8'hFD, 8'h05);
        idle(2);
        check_eq("t1 acc_valid", 64'(av[0]), 64'h1);
        check_eq("t1 acc_out", ao[0], 64'hFFFFF1);
        check_eq("t1 ovf", 64'(ov[0]), 64'h0);
        idle(1);
        check_eq("t1 pulse", 64'(av[0]), 64'h0);

        // Four unsigned 255*255 terms.
        step(0, 1, 1, 0, 0, 8'hFF, 8'hFF);
        step(0, 1, 0, 0, 0, 8'hFF, 8'hFF);
        step(0, 1, 0, 0, 0, 8'hFF, 8'hFF);
        step(0, 1, 0, 1, 0, 8'hFF, 8'hFF);
        check_eq("t2 early", 64'(av[0]), 64'h0);
        idle(2);
        check_eq("t2 acc_out", ao[0], 64'h03F804);
        check_eq("t2 ovf", 64'(ov[0]), 64'h0);

        // Signed overflow in 16 bits, wrapping and saturating, then recovery.
        step(0, 1, 1, 0, 1, 8'd127, 8'd127);
        step(0, 1, 0, 0, 1, 8'd127, 8'd127);
        step(0, 1, 0, 1, 1, 8'd127, 8'd127);
        idle(2);
        check_eq("t3 wrap acc_out", ao[1], 64'hBD03);
        check_eq("t3 wrap ovf", 64'(ov[1]), 64'h1);
        check_eq("t3 sat acc_out", ao[2], 64'h7FFF);
        check_eq("t3 sat ovf", 64'(ov[2]), 64'h1);
        step(0, 1, 1, 1, 1, 8'd2, 8'd3);
        idle(2);
        check_eq("t3 next acc_out", ao[2], 64'h6);
        check_eq("t3 next ovf", 64'(ov[2]), 64'h0);

        // Forwarding and hold.
        step(0, 1, 0, 0, 1, 8'h12, 8'h34);
        check_eq("fwd row", 64'(ro[0]), 64'h12);
        check_eq("fwd valid", 64'(fv[0]), 64'h1);
        idle(1);
        check_eq("fwd hold col", 64'(co[0]), 64'h34);
        check_eq("fwd drop", 64'(fv[0]), 64'h0);

        // Reset flushes an in-flight last term.
        step(0, 1, 1, 1, 1, 8'd2, 8'd2);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst acc_valid", 64'(av[0]), 64'h0);
            check_eq("rst acc_out", ao[0], 64'h0);
            idle(1);
        end

        // Back-to-back dot products with no bubble.
        step(0, 1, 1, 0, 1, 8'd1, 8'd2);
        step(0, 1, 0, 1, 1, 8'd3, 8'd4);
        step(0, 1, 1, 0, 1, 8'd5, 8'd6);
        step(0, 1, 0, 1, 1, 8'd7, 8'd8);
        check_eq("b2b A valid", 64'(av[0]), 64'h1);
        check_eq("b2b A acc_out", ao[0], 64'd14);
        idle(1);
        check_eq("b2b gap", 64'(av[0]), 64'h0);
        idle(1);
        check_eq("b2b B valid", 64'(av[0]), 64'h1);
        check_eq("b2b B acc_out", ao[0], 64'd86);

        // Randomized traffic; signedness only changes on a clr term.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 4) == 0);
            la = ($urandom_range(0, 3) == 0);
            if (v && cl) cur_sgn = 1'($urandom_range(0, 1));
            step(r, v, cl, la, cur_sgn, rand_op(), rand_op());
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
